rgb_fade_sequencer: RTL and testbench



---
 rtl/rgb_ctrl_pkg.sv | 37 +++
 rtl/rgb_fade_sequencer_step_timer.sv | 32 +++
 rtl/rgb_fade_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_ctrl_pkg.sv
// Shared definitions for the RGB fade sequencer: register map, control and
// status bit positions, sequencer states and RGB field packing helpers.
package rgb_ctrl_pkg;

  // Avalon-MM word addresses
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_PERIOD  = 3'd1;
  localparam logic [2:0] ADDR_TARGET  = 3'd2;
  localparam logic [2:0] ADDR_CURRENT = 3'd3;
  localparam logic [2:0] ADDR_STATUS  = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_JUMP_BIT = 1;

  // STATUS bit positions
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;

  // Channel indices within a packed RGB word (red is the most significant field)
  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_STEP      = 2'd2,
    ST_COMMIT    = 2'd3
  } fade_state_e;

  // Bit offset of a channel's field inside a packed {R,G,B} word of width w per channel
  function automatic int rgb_lsb(input int ch, input int w);
    return (2 - ch) * w;
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_step_timer.sv
// Step-period timer: counts up while enabled, clears synchronously, and flags
// terminal count once the count reaches the loaded terminal value.
module step_timer #(
  parameter int TICK_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_count_en,
  input  logic [TICK_W-1:0] i_terminal,
  output logic              o_tc
);

  logic [TICK_W-1:0] r_count;

  // Tick counter with synchronous clear and count enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {TICK_W{1'b0}};
    end else if (i_clear) begin
      r_count <= {TICK_W{1'b0}};
    end else if (i_count_en) begin
      r_count <= r_count + {{(TICK_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  // >= rather than == so a period shortened mid-count still terminates promptly
  assign o_tc = (r_count >= i_terminal);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// RGB fade sequencer: Avalon-MM register block plus a fade FSM that steps the
// staged duties toward a target and commits them to the PWM generators only
// at PWM period boundaries.
module rgb_fade_sequencer
  import rgb_ctrl_pkg::*;
#(
  parameter int DUTY_W = 8,
  parameter int TICK_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  input  logic              pwm_period_done,
  output logic [DUTY_W-1:0] duty_red,
  output logic [DUTY_W-1:0] duty_green,
  output logic [DUTY_W-1:0] duty_blue,
  output logic              duty_valid,
  output logic              busy
);

  localparam int RGB_W = 3 * DUTY_W;
  localparam int R_LSB = rgb_lsb(CH_R, DUTY_W);
  localparam int G_LSB = rgb_lsb(CH_G, DUTY_W);
  localparam int B_LSB = rgb_lsb(CH_B, DUTY_W);
  localparam logic [DUTY_W-1:0] DUTY_ONE = {{(DUTY_W-1){1'b0}}, 1'b1};

  // One saturating-free step toward the target; equal channels stay put, so
  // a channel at either rail can only move toward its target and never wraps.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    logic [DUTY_W-1:0] nxt;
    if (cur < tgt) begin
      nxt = cur + DUTY_ONE;
    end else if (cur > tgt) begin
      nxt = cur - DUTY_ONE;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  // Software-visible registers
  logic              r_enable;
  logic              r_jump;
  logic [TICK_W-1:0] r_period;
  logic [RGB_W-1:0]  r_target;
  logic              r_done;
  logic [31:0]       r_readdata;

  // Fade engine state
  fade_state_e       r_state;
  logic [RGB_W-1:0]  r_stage;
  logic [DUTY_W-1:0] r_duty_red;
  logic [DUTY_W-1:0] r_duty_green;
  logic [DUTY_W-1:0] r_duty_blue;
  logic              r_duty_valid;
  logic              r_busy;

  // Decoded bus strobes and derived values
  logic              w_wr_ctrl;
  logic              w_wr_period;
  logic              w_wr_target;
  logic              w_wr_status;
  logic              w_start;
  logic              w_done_clr;
  logic [RGB_W-1:0]  w_target_nxt;
  logic [RGB_W-1:0]  w_stepped;
  logic [RGB_W-1:0]  w_duty_pack;
  logic              w_tc;
  logic              w_tmr_clear;
  logic              w_tmr_en;
  logic              w_unused_wdata;

  assign w_wr_ctrl    = avs_write && (avs_address == ADDR_CTRL);
  assign w_wr_period  = avs_write && (avs_address == ADDR_PERIOD);
  assign w_wr_target  = avs_write && (avs_address == ADDR_TARGET);
  assign w_wr_status  = avs_write && (avs_address == ADDR_STATUS);
  assign w_start      = w_wr_target && r_enable;
  assign w_done_clr   = w_wr_status && avs_writedata[STAT_DONE_BIT];
  // Completion is judged against the target as it stands after this cycle's write,
  // so a retarget landing on the commit cycle is not lost.
  assign w_target_nxt = w_wr_target ? avs_writedata[RGB_W-1:0] : r_target;
  assign w_duty_pack  = {r_duty_red, r_duty_green, r_duty_blue};
  assign w_unused_wdata = ^avs_writedata;

  // Per-channel single step of the staged value toward the target
  always_comb begin
    w_stepped = r_stage;
    w_stepped[R_LSB +: DUTY_W] = step_toward(r_stage[R_LSB +: DUTY_W], r_target[R_LSB +: DUTY_W]);
    w_stepped[G_LSB +: DUTY_W] = step_toward(r_stage[G_LSB +: DUTY_W], r_target[G_LSB +: DUTY_W]);
    w_stepped[B_LSB +: DUTY_W] = step_toward(r_stage[B_LSB +: DUTY_W], r_target[B_LSB +: DUTY_W]);
  end

  // The timer runs only while waiting for a tick and sits at zero otherwise,
  // so every entry into WAIT_TICK starts a fresh count.
  assign w_tmr_clear = (r_state != ST_WAIT_TICK);
  assign w_tmr_en    = (r_state == ST_WAIT_TICK) && !w_tc;

  step_timer #(
    .TICK_W(TICK_W)
  ) u_step_timer (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_clear    (w_tmr_clear),
    .i_count_en (w_tmr_en),
    .i_terminal (r_period),
    .o_tc       (w_tc)
  );

  // Writable control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable <= 1'b0;
      r_jump   <= 1'b0;
      r_period <= {TICK_W{1'b0}};
      r_target <= {RGB_W{1'b0}};
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= avs_writedata[CTRL_EN_BIT];
        r_jump   <= avs_writedata[CTRL_JUMP_BIT];
      end
      if (w_wr_period) begin
        r_period <= avs_writedata[TICK_W-1:0];
      end
      if (w_wr_target) begin
        r_target <= avs_writedata[RGB_W-1:0];
      end
    end
  end

  // Registered read mux with one cycle of latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
    end else if (avs_read) begin
      case (avs_address)
        ADDR_CTRL:    r_readdata <= {30'd0, r_jump, r_enable};
        ADDR_PERIOD:  r_readdata <= 32'(r_period);
        ADDR_TARGET:  r_readdata <= 32'(r_target);
        ADDR_CURRENT: r_readdata <= 32'(w_duty_pack);
        ADDR_STATUS:  r_readdata <= {30'd0, r_done, r_busy};
        default:      r_readdata <= 32'd0;
      endcase
    end else begin
      r_readdata <= r_readdata;
    end
  end

  // Fade FSM: wait a step period, step the staged value, commit at a PWM boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_stage      <= {RGB_W{1'b0}};
      r_duty_red   <= {DUTY_W{1'b0}};
      r_duty_green <= {DUTY_W{1'b0}};
      r_duty_blue  <= {DUTY_W{1'b0}};
      r_duty_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_duty_valid <= 1'b0;
      // A set in the COMMIT branch below overrides this clear in the same cycle
      if (w_done_clr) begin
        r_done <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_WAIT_TICK;
            r_busy  <= 1'b1;
          end
        end
        ST_WAIT_TICK: begin
          if (!r_enable) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_tc) begin
            r_state <= ST_STEP;
          end
        end
        ST_STEP: begin
          r_stage <= r_jump ? r_target : w_stepped;
          r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (pwm_period_done) begin
            r_duty_red   <= r_stage[R_LSB +: DUTY_W];
            r_duty_green <= r_stage[G_LSB +: DUTY_W];
            r_duty_blue  <= r_stage[B_LSB +: DUTY_W];
            r_duty_valid <= 1'b1;
            if (!r_enable) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else if (r_stage == w_target_nxt) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_WAIT_TICK;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign avs_readdata = r_readdata;
  assign duty_red     = r_duty_red;
  assign duty_green   = r_duty_green;
  assign duty_blue    = r_duty_blue;
  assign duty_valid   = r_duty_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed self-checking bench for rgb_fade_sequencer.
module tb_rgb_fade_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        pwm_period_done;
  logic [7:0]  duty_red;
  logic [7:0]  duty_green;
  logic [7:0]  duty_blue;
  logic        duty_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int pwm_cnt = 0;
  bit pwm_auto = 1'b0;

  always #5 clk = ~clk;

  rgb_fade_sequencer #(.DUTY_W(8), .TICK_W(24)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .pwm_period_done (pwm_period_done),
    .duty_red        (duty_red),
    .duty_green      (duty_green),
    .duty_blue       (duty_blue),
    .duty_valid      (duty_valid),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (pwm_auto) begin
      pwm_cnt++;
      pwm_period_done = (pwm_cnt % 10 == 0);
    end
  endtask

  task automatic avs_wr(input logic [2:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic avs_rd(input logic [2:0] addr, output logic [31:0] data);
    avs_address = addr;
    avs_read    = 1'b1;
    tick();
    avs_read    = 1'b0;
    data        = avs_readdata;
  endtask

  task automatic wait_strobe(input int max_cycles, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      tick();
      if (duty_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic count_strobes(input int n_cycles, output int n);
    n = 0;
    for (int i = 0; i < n_cycles; i++) begin
      tick();
      if (duty_valid === 1'b1) n++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    bit          got;
    int          n;

    reset_n         = 1'b0;
    avs_address     = 3'd0;
    avs_read        = 1'b0;
    avs_write       = 1'b0;
    avs_writedata   = 32'd0;
    pwm_period_done = 1'b0;
    do_reset();

    // Reset state
    check("rst_duty_r", {24'd0, duty_red}, 32'd0);
    check("rst_duty_g", {24'd0, duty_green}, 32'd0);
    check("rst_duty_b", {24'd0, duty_blue}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, duty_valid}, 32'd0);
    for (int a = 0; a < 5; a++) begin
      avs_rd(3'(a), rd);
      check($sformatf("rst_reg%0d", a), rd, 32'd0);
    end
    // Unused address: write ignored, reads zero
    avs_wr(3'd5, 32'hDEADBEEF);
    avs_rd(3'd5, rd);
    check("unused_addr", rd, 32'd0);

    // Basic fade: period 3, target R=4 G=0 B=2
    pwm_auto = 1'b1;
    avs_wr(3'd0, 32'h1);
    avs_wr(3'd1, 32'd3);
    check("busy_before_start", {31'd0, busy}, 32'd0);
    avs_wr(3'd2, 32'h040002);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      wait_strobe(40, got);
      check($sformatf("fade_strobe%0d", k), {31'd0, got}, 32'd1);
      check($sformatf("fade_r%0d", k), {24'd0, duty_red}, 32'(k));
      check($sformatf("fade_g%0d", k), {24'd0, duty_green}, 32'd0);
      check($sformatf("fade_b%0d", k), {24'd0, duty_blue}, (k < 2) ? 32'(k) : 32'd2);
      check($sformatf("fade_busy%0d", k), {31'd0, busy}, (k < 4) ? 32'd1 : 32'd0);
    end
    avs_rd(3'd4, rd);
    check("fade_status_done", rd, 32'h2);
    avs_rd(3'd1, rd);
    check("period_readback", rd, 32'd3);
    avs_rd(3'd2, rd);
    check("target_readback", rd, 32'h040002);
    avs_rd(3'd3, rd);
    check("current_readback", rd, 32'h040002);
    count_strobes(40, n);
    check("fade_no_extra", 32'(n), 32'd0);

    // Async reset mid-fade
    avs_wr(3'd2, 32'h000000);
    wait_strobe(40, got);
    check("midrst_strobe", {31'd0, got}, 32'd1);
    check("midrst_r_before", {24'd0, duty_red}, 32'd3);
    check("midrst_b_before", {24'd0, duty_blue}, 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_r", {24'd0, duty_red}, 32'd0);
    check("midrst_b", {24'd0, duty_blue}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    do_reset();

    // Jump straight to 0xFF00FF
    avs_wr(3'd0, 32'h3);
    avs_wr(3'd1, 32'd3);
    avs_wr(3'd2, 32'hFF00FF);
    wait_strobe(40, got);
    check("jump_strobe", {31'd0, got}, 32'd1);
    check("jump_r", {24'd0, duty_red}, 32'd255);
    check("jump_g", {24'd0, duty_green}, 32'd0);
    check("jump_b", {24'd0, duty_blue}, 32'd255);
    check("jump_busy", {31'd0, busy}, 32'd0);
    count_strobes(40, n);
    check("jump_single_commit", 32'(n), 32'd0);
    avs_rd(3'd4, rd);
    check("jump_status", rd, 32'h2);
    avs_wr(3'd4, 32'h2);
    avs_rd(3'd4, rd);
    check("done_w1c", rd, 32'h0);

    // Retarget R from 10 to 5 at R=7
    do_reset();
    avs_wr(3'd0, 32'h1);
    avs_wr(3'd1, 32'd3);
    avs_wr(3'd2, 32'h0A0000);
    for (int k = 1; k <= 7; k++) begin
      wait_strobe(40, got);
      check($sformatf("rt_r%0d", k), {24'd0, duty_red}, 32'(k));
    end
    avs_wr(3'd2, 32'h050000);
    wait_strobe(40, got);
    check("rt_r6", {24'd0, duty_red}, 32'd6);
    check("rt_busy6", {31'd0, busy}, 32'd1);
    wait_strobe(40, got);
    check("rt_r5", {24'd0, duty_red}, 32'd5);
    check("rt_busy5", {31'd0, busy}, 32'd0);
    avs_rd(3'd4, rd);
    check("rt_status", rd, 32'h2);

    // Clear enable at R=3 while fading toward 8
    do_reset();
    avs_wr(3'd0, 32'h1);
    avs_wr(3'd1, 32'd3);
    avs_wr(3'd2, 32'h080000);
    for (int k = 1; k <= 3; k++) begin
      wait_strobe(40, got);
      check($sformatf("en_r%0d", k), {24'd0, duty_red}, 32'(k));
    end
    avs_wr(3'd0, 32'h0);
    tick();
    tick();
    check("en_off_busy", {31'd0, busy}, 32'd0);
    count_strobes(40, n);
    check("en_off_no_strobe", 32'(n), 32'd0);
    check("en_off_r_hold", {24'd0, duty_red}, 32'd3);
    avs_rd(3'd4, rd);
    check("en_off_status", rd, 32'h0);
    avs_wr(3'd0, 32'h1);
    avs_wr(3'd2, 32'h080000);
    check("en_resume_busy", {31'd0, busy}, 32'd1);
    wait_strobe(40, got);
    check("en_resume_r4", {24'd0, duty_red}, 32'd4);

    // Hold pwm_period_done low while COMMIT waits
    pwm_auto = 1'b0;
    pwm_period_done = 1'b0;
    count_strobes(100, n);
    check("hold_no_strobe", 32'(n), 32'd0);
    check("hold_r", {24'd0, duty_red}, 32'd4);
    check("hold_busy", {31'd0, busy}, 32'd1);
    pwm_period_done = 1'b1;
    tick();
    pwm_period_done = 1'b0;
    check("hold_release_valid", {31'd0, duty_valid}, 32'd1);
    check("hold_release_r", {24'd0, duty_red}, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
